// File: rtl/cic_frame_collector.sv
// cic_frame_collector: Avalon-ST sink for the cic decimator's channel stream.
// Checks framing (SOP on channel 0, EOP on channel NUM_CH-1, channels in
// order), assembles each good frame into one parallel NUM_CH-lane word and
// drops malformed frames. Upstream error bits are ORed per frame.
// Optional feature: define CIC_COLLECT_DROP_COUNT_EN to implement the
// saturating drop counter; otherwise drop_count is tied to zero.
module cic_frame_collector #(
    parameter int NUM_CH = 9,
    parameter int DATA_W = 19,
    parameter int CH_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [CH_W-1:0]          in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic [1:0]               in_error,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_frame,
    output logic [1:0]               out_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              drop_count
);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CH_W-1:0]         r_exp;
    logic [CH_W-1:0]         w_exp_nxt;

    logic [DATA_W-1:0]       r_lane [NUM_CH];
    logic [1:0]              r_err;

    logic [NUM_CH*DATA_W-1:0] r_out_frame;
    logic [1:0]              r_out_error;
    logic                    r_out_valid;

    logic                    w_acc;
    logic                    w_is_start;
    logic                    w_is_last;
    logic                    w_good;
    logic                    w_last_pending;
    logic                    w_start;
    logic                    w_wr;
    logic                    w_commit;
    logic                    w_drop;
    logic [NUM_CH*DATA_W-1:0] w_frame_nxt;
    logic [1:0]              w_err_nxt;

    assign w_acc          = in_valid && in_ready;
    assign w_is_last      = (r_exp == LAST_CH);
    assign w_is_start     = in_startofpacket && (in_channel == '0) &&
                            ((NUM_CH != 1) || in_endofpacket);
    assign w_good         = (in_channel == r_exp) && !in_startofpacket &&
                            (in_endofpacket == w_is_last);
    assign w_last_pending = ((r_state == COLLECT) && w_is_last) ||
                            ((r_state == HUNT) && (NUM_CH == 1));

    // State register: framing state and expected-channel counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HUNT;
            r_exp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    // Next-state logic: classify each accepted beat and decide start/write/commit/drop
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_acc && w_is_start) begin
                    w_start = 1'b1;
                    if (NUM_CH == 1) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = COLLECT;
                        w_exp_nxt   = CH_W'(1);
                    end
                end
            end
            COLLECT: begin
                if (w_acc) begin
                    if (w_good) begin
                        w_wr = 1'b1;
                        if (w_is_last) begin
                            w_commit    = 1'b1;
                            w_state_nxt = HUNT;
                            w_exp_nxt   = '0;
                        end else begin
                            w_exp_nxt = r_exp + 1'b1;
                        end
                    end else begin
                        w_drop = 1'b1;
                        if (w_is_start) begin
                            // A fresh SOP resynchronises immediately instead of waiting in HUNT
                            w_start   = 1'b1;
                            w_exp_nxt = CH_W'(1);
                        end else begin
                            w_state_nxt = HUNT;
                            w_exp_nxt   = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_exp_nxt   = '0;
            end
        endcase
    end

    // Output logic: stall only the final beat while the held frame is unconsumed
    always_comb begin
        in_ready = !(w_last_pending && r_out_valid && !out_ready);
    end

    // Committed word: stored lanes with the in-flight last beat bypassed in
    always_comb begin
        w_frame_nxt = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (r_exp == CH_W'(k)) begin
                w_frame_nxt[k*DATA_W +: DATA_W] = in_data;
            end else begin
                w_frame_nxt[k*DATA_W +: DATA_W] = r_lane[k];
            end
        end
        w_err_nxt = w_start ? in_error : (r_err | in_error);
    end

    // Lane storage and sticky error for the frame being assembled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_lane[k] <= '0;
            end
            r_err <= '0;
        end else if (w_start) begin
            r_lane[0] <= in_data;
            r_err     <= in_error;
        end else if (w_wr) begin
            r_lane[r_exp] <= in_data;
            r_err         <= r_err | in_error;
        end
    end

    // Output register: commit wins over a same-cycle handshake, so no bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_frame <= '0;
            r_out_error <= '0;
            r_out_valid <= 1'b0;
        end else if (w_commit) begin
            r_out_frame <= w_frame_nxt;
            r_out_error <= w_err_nxt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_frame = r_out_frame;
    assign out_error = r_out_error;
    assign out_valid = r_out_valid;

`ifdef CIC_COLLECT_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    // Saturating count of dropped partial frames
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
    assign drop_count    = '0;
`endif

endmodule

// File: tb/tb_cic_frame_collector.sv
// Testbench for cic_frame_collector: table-driven directed vectors, hand
// sequences for backpressure / resync / mid-frame reset, and random traffic,
// all scored against a queue-based frame model.
module tb_cic_frame_collector;

    localparam int NUM_CH = 9;
    localparam int DATA_W = 19;
    localparam int CH_W   = 4;
    localparam int FW     = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_channel;
    logic              in_startofpacket;
    logic              in_endofpacket;
    logic [1:0]        in_error;
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     out_frame;
    logic [1:0]        out_error;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       drop_count;

    cic_frame_collector #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_error         (in_error),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_frame        (out_frame),
        .out_error        (out_error),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int unsigned xdrop(input int unsigned n);
`ifdef CIC_COLLECT_DROP_COUNT_EN
        return (n > 16'hFFFF) ? 16'hFFFF : n;
`else
        return 0;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [FW-1:0] f;
        logic [1:0]    e;
    } frm_t;

    logic [DATA_W-1:0] m_part[$];
    logic [1:0]        m_err;
    frm_t              m_q[$];
    int unsigned       m_drop;

    task automatic model_reset();
        m_part.delete();
        m_q.delete();
        m_err  = '0;
        m_drop = 0;
    endtask

    task automatic model_beat(input int unsigned ch, input logic [DATA_W-1:0] d,
                              input bit sop, input bit eop, input logic [1:0] err);
        bit          st;
        int unsigned n;
        frm_t        fr;
        st = sop && (ch == 0);
        n  = m_part.size();
        if (n == 0) begin
            if (st) begin m_part.push_back(d); m_err = err; end
        end else if ((ch == n) && !sop && (eop == (n == NUM_CH - 1))) begin
            m_part.push_back(d);
            m_err = m_err | err;
        end else begin
            m_drop++;
            m_part.delete();
            if (st) begin m_part.push_back(d); m_err = err; end
        end
        if (m_part.size() == NUM_CH) begin
            fr.f = '0;
            for (int k = 0; k < NUM_CH; k++) fr.f[k*DATA_W +: DATA_W] = m_part[k];
            fr.e = m_err;
            m_q.push_back(fr);
            m_part.delete();
        end
    endtask

    bit obs_rdy;

    task automatic drive(input bit v, input int unsigned ch, input logic [DATA_W-1:0] d,
                         input bit sop, input bit eop, input logic [1:0] err, input bit ordy);
        in_valid         = v;
        in_channel       = CH_W'(ch);
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_error         = err;
        out_ready        = ordy;
    endtask

    // Called at the negedge: compare DUT to model, then let the model see this cycle's beat.
    task automatic model_check(output bit acc);
        bit x_rdy;
        obs_rdy = in_ready;
        x_rdy = !((m_part.size() == NUM_CH - 1) && (m_q.size() > 0) && !out_ready);
        chk("in_ready", in_ready, x_rdy);
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("drop_count", drop_count, xdrop(m_drop));
        if ((m_q.size() > 0) && out_ready) begin
            chk("out_frame", out_frame, m_q[0].f);
            chk("out_error", out_error, m_q[0].e);
            void'(m_q.pop_front());
        end
        acc = in_valid && x_rdy;
        if (acc) model_beat(in_channel, in_data, in_startofpacket, in_endofpacket, in_error);
    endtask

    task automatic step(input bit v, input int unsigned ch, input logic [DATA_W-1:0] d,
                        input bit sop, input bit eop, input logic [1:0] err, input bit ordy,
                        output bit acc);
        drive(v, ch, d, sop, eop, err, ordy);
        @(negedge clk);
        model_check(acc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n, input bit ordy);
        bit a;
        for (int unsigned i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, ordy, a);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit                v;
        int unsigned       ch;
        logic [DATA_W-1:0] d;
        bit                sop;
        bit                eop;
        logic [1:0]        err;
        bit                ordy;
        bit                x_rdy;
        bit                x_ov;
        logic [1:0]        x_err;
        int unsigned       x_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add_frame(input logic [DATA_W-1:0] base, input int skip_ch,
                             input int err_ch, input logic [1:0] errv, input int unsigned drop);
        vec_t r;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == skip_ch) continue;
            r.v = 1; r.ch = k; r.d = base + DATA_W'(k);
            r.sop = (k == 0); r.eop = (k == NUM_CH - 1);
            r.err = (k == err_ch) ? errv : 2'b00;
            r.ordy = 1; r.x_rdy = 1; r.x_ov = 0; r.x_err = '0;
            r.x_drop = ((skip_ch >= 0) && (k > skip_ch + 1)) ? drop + 1 : drop;
            tbl.push_back(r);
        end
    endtask

    task automatic add_idle(input bit x_ov, input logic [1:0] x_err, input int unsigned drop);
        vec_t r;
        r.v = 0; r.ch = 0; r.d = '0; r.sop = 0; r.eop = 0; r.err = '0; r.ordy = 1;
        r.x_rdy = 1; r.x_ov = x_ov; r.x_err = x_err; r.x_drop = drop;
        tbl.push_back(r);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit          acc;
        int unsigned cyc;
        int unsigned low_rdy;
        int unsigned pos;

        reset_n = 1'b0;
        drive(0, 0, '0, 0, 0, '0, 1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_frame", out_frame, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;

        // Clean frame, skipped channel 4, clean frame, error on channel 3
        add_frame(19'h00001, -1, -1, 2'b00, 0);  add_idle(1, 2'b00, 0);
        add_frame(19'h00200,  4, -1, 2'b00, 0);  add_idle(0, 2'b00, 1);
        add_frame(19'h00300, -1, -1, 2'b00, 1);  add_idle(1, 2'b00, 1);
        add_frame(19'h00400, -1,  3, 2'b10, 1);  add_idle(1, 2'b10, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].sop, tbl[i].eop, tbl[i].err, tbl[i].ordy);
            @(negedge clk);
            chk("tbl_in_ready", in_ready, tbl[i].x_rdy);
            chk("tbl_out_valid", out_valid, tbl[i].x_ov);
            chk("tbl_drop", drop_count, xdrop(tbl[i].x_drop));
            if (tbl[i].x_ov) chk("tbl_out_error", out_error, tbl[i].x_err);
            model_check(acc);
            @(posedge clk);
            #1;
        end
        idle(2, 1);

        // Back-to-back frames with out_ready low for the first 20 cycles
        cyc = 0;
        low_rdy = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc = 0;
                while (!acc && cyc < 200) begin
                    step(1, k, DATA_W'(f * 16'h100 + 16'h1000 + k), k == 0, k == NUM_CH - 1,
                         '0, cyc >= 20, acc);
                    if (!obs_rdy) low_rdy++;
                    cyc++;
                end
                chk("bp_beat_accepted", acc, 1);
            end
        end
        chk("bp_stall_cycles", low_rdy, 3);
        idle(3, 1);

        // SOP on channel 0 while expecting channel 6: resync onto the new frame
        for (int k = 0; k < 6; k++) step(1, k, DATA_W'(16'h2000 + k), k == 0, 0, '0, 1, acc);
        for (int k = 0; k < NUM_CH; k++)
            step(1, k, DATA_W'(16'h3000 + k), k == 0, k == NUM_CH - 1, '0, 1, acc);
        idle(2, 1);

        // Reset while a frame is held and the next one is at channel 5
        for (int k = 0; k < NUM_CH; k++)
            step(1, k, DATA_W'(16'h4000 + k), k == 0, k == NUM_CH - 1, 2'b01, 0, acc);
        for (int k = 0; k < 5; k++) step(1, k, DATA_W'(16'h5000 + k), k == 0, 0, '0, 0, acc);
        chk("pre_rst_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_frame", out_frame, 0);
        chk("mid_rst_out_error", out_error, 0);
        chk("mid_rst_drop", drop_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < NUM_CH; k++)
            step(1, k, DATA_W'(16'h6000 + k), k == 0, k == NUM_CH - 1, '0, 1, acc);
        idle(2, 1);

        // Random traffic: mostly well-formed beats with occasional corruption
        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            bit                v, sop, eop, ordy;
            int unsigned       ch;
            logic [1:0]        err;
            v    = ($urandom_range(99) < 75);
            ordy = ($urandom_range(99) < 70);
            err  = ($urandom_range(99) < 5) ? 2'($urandom_range(3)) : 2'b00;
            if ($urandom_range(99) < 90) begin
                ch = pos; sop = (pos == 0); eop = (pos == NUM_CH - 1);
            end else begin
                ch = $urandom_range(15); sop = $urandom_range(1); eop = $urandom_range(1);
            end
            step(v, ch, DATA_W'($urandom), sop, eop, err, ordy, acc);
            if (acc) pos = (pos + 1) % NUM_CH;
        end
        idle(4, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
